// File: rtl/iig_pkg.sv
// Shared definitions for the integral-image generator ping-pong line buffer.
// Bank state encoding and default line geometry.
package iig_pkg;

    localparam logic [1:0] BK_EMPTY    = 2'd0;
    localparam logic [1:0] BK_FILLING  = 2'd1;
    localparam logic [1:0] BK_FULL     = 2'd2;
    localparam logic [1:0] BK_DRAINING = 2'd3;

    localparam int IIG_DATA_W = 21;
    localparam int IIG_LINE_W = 80;

    function automatic logic bk_writable(input logic [1:0] st);
        return (st == BK_EMPTY) || (st == BK_FILLING);
    endfunction

    function automatic logic bk_readable(input logic [1:0] st);
        return (st == BK_FULL) || (st == BK_DRAINING);
    endfunction

endpackage

// File: rtl/iig_ppbuf_bank.sv
// One bank of the ping-pong line buffer: DEPTH x DATA_W RAM with registered read,
// fill count (also the write index), read index and bank state.
module iig_ppbuf_bank
    import iig_pkg::*;
#(
    parameter int DATA_W = IIG_DATA_W,
    parameter int DEPTH  = IIG_LINE_W,
    parameter int AW     = $clog2(DEPTH + 1)
) (
    input  logic              iClk,
    input  logic              clr,
    input  logic              we,
    input  logic              wlast,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    output logic [1:0]        state,
    output logic [AW-1:0]     fill,
    output logic [AW-1:0]     rd_idx,
    output logic [DATA_W-1:0] rdata_p1,
    output logic              rlast_p1
);

    localparam int          IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              rd_final;

    assign rd_final = (rd_idx == fill - AW'(1));

    always_ff @(posedge iClk) begin
        if (we) begin
            mem[fill[IW-1:0]] <= wdata;
        end
    end

    // A bank is never written and read in the same cycle: the two states are disjoint.
    always_ff @(posedge iClk) begin
        if (clr) begin
            state  <= BK_EMPTY;
            fill   <= '0;
            rd_idx <= '0;
        end else if (we) begin
            fill  <= fill + AW'(1);
            state <= (wlast || fill == LAST_IDX) ? BK_FULL : BK_FILLING;
        end else if (re) begin
            if (rd_final) begin
                state  <= BK_EMPTY;
                fill   <= '0;
                rd_idx <= '0;
            end else begin
                state  <= BK_DRAINING;
                rd_idx <= rd_idx + AW'(1);
            end
        end
    end

    // p1: registered RAM read
    always_ff @(posedge iClk) begin
        if (clr) begin
            rdata_p1 <= '0;
            rlast_p1 <= 1'b0;
        end else if (re) begin
            rdata_p1 <= mem[rd_idx[IW-1:0]];
            rlast_p1 <= rd_final;
        end
    end

endmodule

// File: rtl/iig_ppbuf_ctrl.sv
// Ping-pong line buffer controller for the IIG datapath: bank pointers, handshakes, output mux.
// Optional sticky overflow/underflow flags are enabled by defining IIG_PPBUF_ERR_EN.
module iig_ppbuf_ctrl
    import iig_pkg::*;
#(
    parameter  int DATA_W = IIG_DATA_W,
    parameter  int DEPTH  = IIG_LINE_W,
    localparam int AW     = $clog2(DEPTH + 1)
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iFlush,
    input  logic              iWrreq,
    input  logic              iLast,
    input  logic [DATA_W-1:0] iData,
    output logic              oWrReady,
    input  logic              iRdreq,
    output logic              oRdAvail,
    output logic              oValid,
    output logic [DATA_W-1:0] oData,
    output logic              oLast,
`ifdef IIG_PPBUF_ERR_EN
    output logic              oOverflow,
    output logic              oUnderflow,
`endif
    output logic [AW-1:0]     oLevel
);

    logic              clr;
    logic              wr_bank, rd_bank;
    logic              wr_acc, rd_acc;
    logic              rd_close;
    logic              vld_p1, sel_p1;
    logic [1:0]        bk_state [2];
    logic [AW-1:0]     bk_fill  [2];
    logic [AW-1:0]     bk_rdidx [2];
    logic [DATA_W-1:0] bk_rdata [2];
    logic              bk_rlast [2];

    assign clr      = iReset | iFlush;
    assign oWrReady = bk_writable(bk_state[wr_bank]);
    assign oRdAvail = bk_readable(bk_state[rd_bank]);
    assign wr_acc   = iWrreq & oWrReady & ~clr;
    assign rd_acc   = iRdreq & oRdAvail & ~clr;
    assign rd_close = rd_acc & (bk_rdidx[rd_bank] == bk_fill[rd_bank] - AW'(1));

    for (genvar b = 0; b < 2; b++) begin : g_bank
        iig_ppbuf_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .AW     (AW)
        ) u_bank (
            .iClk     (iClk),
            .clr      (clr),
            .we       (wr_acc & (wr_bank == 1'(b))),
            .wlast    (iLast),
            .wdata    (iData),
            .re       (rd_acc & (rd_bank == 1'(b))),
            .state    (bk_state[b]),
            .fill     (bk_fill[b]),
            .rd_idx   (bk_rdidx[b]),
            .rdata_p1 (bk_rdata[b]),
            .rlast_p1 (bk_rlast[b])
        );
    end

    // Pointers toggle independently, so a close and a drain in one cycle swap with no bubble.
    always_ff @(posedge iClk) begin
        if (clr) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            vld_p1  <= 1'b0;
            sel_p1  <= 1'b0;
        end else begin
            if (wr_acc && (iLast || bk_fill[wr_bank] == AW'(DEPTH - 1))) begin
                wr_bank <= ~wr_bank;
            end
            if (rd_close) begin
                rd_bank <= ~rd_bank;
            end
            vld_p1 <= rd_acc;
            if (rd_acc) begin
                sel_p1 <= rd_bank;
            end
        end
    end

    // p1: output stage, selected from the bank read on the previous cycle
    assign oValid = vld_p1;
    assign oData  = bk_rdata[sel_p1];
    assign oLast  = vld_p1 & bk_rlast[sel_p1];

    always_comb begin
        oLevel = '0;
        if (oRdAvail) begin
            oLevel = bk_fill[rd_bank] - bk_rdidx[rd_bank];
        end
    end

`ifdef IIG_PPBUF_ERR_EN
    always_ff @(posedge iClk) begin
        if (clr) begin
            oOverflow  <= 1'b0;
            oUnderflow <= 1'b0;
        end else begin
            if (iWrreq && !oWrReady) begin
                oOverflow <= 1'b1;
            end
            if (iRdreq && !oRdAvail) begin
                oUnderflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_iig_ppbuf_ctrl.sv
// Scoreboard bench for iig_ppbuf_ctrl: stimulus queues expectations, a negedge monitor checks them.
module tb_iig_ppbuf_ctrl;

    localparam int DATA_W = 21;
    localparam int DEPTH  = 80;
    localparam int AW     = $clog2(DEPTH + 1);

    localparam int C_WR = 0, C_RD = 1, C_LVL = 2, C_VLD = 3, C_DAT = 4;
    localparam int C_LST = 5, C_OVF = 6, C_UNF = 7, C_QE = 8;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              l;
    } rd_t;

    typedef struct {
        int          id;
        logic [31:0] exp;
    } chk_t;

    logic              iClk, iReset, iFlush, iWrreq, iLast, iRdreq;
    logic [DATA_W-1:0] iData;
    logic              oWrReady, oRdAvail, oValid, oLast;
    logic [DATA_W-1:0] oData;
    logic [AW-1:0]     oLevel;
`ifdef IIG_PPBUF_ERR_EN
    logic              oOverflow, oUnderflow;
`endif

    iig_ppbuf_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .iClk       (iClk),
        .iReset     (iReset),
        .iFlush     (iFlush),
        .iWrreq     (iWrreq),
        .iLast      (iLast),
        .iData      (iData),
        .oWrReady   (oWrReady),
        .iRdreq     (iRdreq),
        .oRdAvail   (oRdAvail),
        .oValid     (oValid),
        .oData      (oData),
        .oLast      (oLast),
`ifdef IIG_PPBUF_ERR_EN
        .oOverflow  (oOverflow),
        .oUnderflow (oUnderflow),
`endif
        .oLevel     (oLevel)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    rd_t   exp_q [$];
    chk_t  sq [$];
    int    n_vec = 0;
    int    n_err = 0;
    rd_t   mon_e;
    chk_t  mon_c;
    logic [31:0] mon_a;
    string names [9] = '{"wr_ready", "rd_avail", "level", "valid", "data", "last",
                         "overflow", "underflow", "pending_reads"};

    function automatic logic [31:0] act(input int id);
        case (id)
            C_WR:    return 32'(oWrReady);
            C_RD:    return 32'(oRdAvail);
            C_LVL:   return 32'(oLevel);
            C_VLD:   return 32'(oValid);
            C_DAT:   return 32'(oData);
            C_LST:   return 32'(oLast);
`ifdef IIG_PPBUF_ERR_EN
            C_OVF:   return 32'(oOverflow);
            C_UNF:   return 32'(oUnderflow);
`endif
            C_QE:    return 32'(exp_q.size());
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(negedge iClk) begin
        if (oValid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: got data %0d last %0b, required no oValid", oData, oLast);
            end else begin
                mon_e = exp_q.pop_front();
                if (oData !== mon_e.d || oLast !== mon_e.l) begin
                    n_err++;
                    $display("FAIL read_word: got data %0d last %0b, required data %0d last %0b",
                             oData, oLast, mon_e.d, mon_e.l);
                end
            end
        end
        while (sq.size() > 0) begin
            mon_c = sq.pop_front();
            mon_a = act(mon_c.id);
            n_vec++;
            if (mon_a !== mon_c.exp) begin
                n_err++;
                $display("FAIL %s: got %0d, required %0d", names[mon_c.id], mon_a, mon_c.exp);
            end
        end
    end

    task automatic drive(input logic w, input logic l, input int d, input logic r, input logic f);
        iWrreq = w;
        iLast  = l;
        iData  = DATA_W'(d);
        iRdreq = r;
        iFlush = f;
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
        iWrreq = 1'b0;
        iLast  = 1'b0;
        iRdreq = 1'b0;
        iFlush = 1'b0;
    endtask

    task automatic post(input int id, input int e);
        sq.push_back('{id, 32'(e)});
    endtask

    task automatic expect_rd(input int d, input logic l);
        exp_q.push_back('{DATA_W'(d), l});
    endtask

    function automatic int stream_val(input int k);
        return (k < DEPTH) ? 1000 + k : 2000 + k - DEPTH;
    endfunction

    initial begin
        iReset = 1'b1;
        drive(0, 0, 0, 0, 0);
        repeat (3) @(posedge iClk);
        #1;
        iReset = 1'b0;

        // Reset state
        post(C_WR, 1); post(C_RD, 0); post(C_LVL, 0);
        post(C_VLD, 0); post(C_DAT, 0); post(C_LST, 0);

        // Read with nothing available
        drive(0, 0, 0, 1, 0); post(C_RD, 0); tick();
        post(C_VLD, 0);
`ifdef IIG_PPBUF_ERR_EN
        post(C_UNF, 1); post(C_OVF, 0);
        drive(0, 0, 0, 0, 1); tick();
        post(C_UNF, 0);
`endif

        // One full line, no reads
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 0, i, 0, 0);
            post(C_WR, 1);
            if (i == DEPTH - 1) post(C_RD, 0);
            tick();
        end
        post(C_RD, 1); post(C_LVL, 80); post(C_WR, 1);

        // Second line fills both banks; a further write is dropped
        for (int i = DEPTH; i < 2 * DEPTH; i++) begin
            drive(1, 0, i, 0, 0); post(C_WR, 1); tick();
        end
        post(C_WR, 0); post(C_LVL, 80);
        drive(1, 0, 999, 0, 0); tick();
        post(C_LVL, 80); post(C_RD, 1);
`ifdef IIG_PPBUF_ERR_EN
        post(C_OVF, 1);
`endif
        for (int k = 0; k < 2 * DEPTH; k++) begin
            drive(0, 0, 0, 1, 0);
            post(C_RD, 1);
            if (k == 0) post(C_LVL, 80);
            if (k == DEPTH - 1) post(C_LVL, 1);
            if (k == DEPTH) post(C_LVL, 80);
            expect_rd(k, (k == DEPTH - 1) || (k == 2 * DEPTH - 1));
            tick();
        end
        tick();
        post(C_RD, 0); post(C_LVL, 0); post(C_WR, 1);
`ifdef IIG_PPBUF_ERR_EN
        post(C_OVF, 1);
        drive(0, 0, 0, 0, 1); tick();
        post(C_OVF, 0);
`endif

        // Short line of 5, then a 2-word line proving the read pointer moved
        for (int i = 0; i < 5; i++) begin
            drive(1, i == 4, i, 0, 0); tick();
        end
        post(C_LVL, 5); post(C_RD, 1); post(C_WR, 1);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 0); post(C_LVL, 5 - i); expect_rd(i, i == 4); tick();
        end
        tick();
        post(C_RD, 0); post(C_LVL, 0);
        drive(1, 0, 50, 0, 0); tick();
        post(C_RD, 0); post(C_LVL, 0);
        drive(1, 1, 51, 0, 0); tick();
        post(C_RD, 1); post(C_LVL, 2);
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 1, 0); expect_rd(50 + i, i == 1); tick();
        end
        tick();
        post(C_RD, 0); post(C_WR, 1);

        // Prime one bank, then stream both sides at full rate
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 0, 1000 + i, 0, 0); tick();
        end
        for (int k = 0; k < 400; k++) begin
            drive(1, 0, 2000 + k, 1, 0);
            post(C_WR, 1); post(C_RD, 1);
            expect_rd(stream_val(k), (k % DEPTH) == DEPTH - 1);
            tick();
        end
        for (int k = 400; k < 400 + DEPTH; k++) begin
            drive(0, 0, 0, 1, 0);
            post(C_RD, 1);
            expect_rd(stream_val(k), (k % DEPTH) == DEPTH - 1);
            tick();
        end
        tick();
        post(C_RD, 0); post(C_LVL, 0); post(C_WR, 1);

        // Flush mid-line with simultaneous write and read
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 0, 3000 + i, 0, 0); tick();
        end
        for (int i = 0; i < 40; i++) begin
            drive(1, 0, 4000 + i, 0, 0); tick();
        end
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 1, 0); expect_rd(3000 + i, 1'b0); tick();
        end
        drive(1, 0, 777, 1, 1); tick();
        post(C_RD, 0); post(C_LVL, 0); post(C_WR, 1);
        post(C_VLD, 0); post(C_DAT, 0); post(C_LST, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, i == 2, 7 + i, 0, 0); tick();
        end
        post(C_LVL, 3);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 0); expect_rd(7 + i, i == 2); tick();
        end
        tick();
        post(C_RD, 0);

        repeat (3) tick();
        post(C_QE, 0);
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
